// File: rtl/aes_pkg.sv
// Shared AES constants and the state encoding used by the state-RAM reader.
package aes_pkg;
   localparam int AES_BLOCK_BYTES = 16;
   localparam int AES_ADDR_W      = 4;
   localparam int AES_BYTE_W      = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } rd_state_t;
endpackage

// File: rtl/aes_byte_out_reg.sv
// Single-entry output holding register with valid/ready slot handling.
module aes_byte_out_reg
   import aes_pkg::*;
#(
   parameter int DATA_W = AES_BYTE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              last_o,
   output logic              slot_free_o
);
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
         last_q  <= last_i;
      end else if (valid_q && ready_i) begin
         // accepted with nothing to refill: slot drains
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

   assign slot_free_o = !valid_q || ready_i;
   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign last_o      = last_q;
endmodule

// File: rtl/aes_state_reader.sv
// Reads the 16-byte AES state RAM in order and streams it over a valid/ready byte port.
// Optional AES_STATE_READER_BLOCK_OUT_EN adds a parallel block_out/block_valid view.
module aes_state_reader
   import aes_pkg::*;
#(
   parameter int NUM_BYTES = AES_BLOCK_BYTES,
   parameter int ADDR_W    = AES_ADDR_W,
   parameter int DATA_W    = AES_BYTE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
`ifdef AES_STATE_READER_BLOCK_OUT_EN
   ,
   output logic [NUM_BYTES*DATA_W-1:0] block_out,
   output logic                        block_valid
`endif
);
   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;
   logic              slot_free;
   logic              load;
   logic              addr_is_last;

   assign addr_is_last = (addr_q == ADDR_W'(NUM_BYTES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      if (abort) begin
         state_d = IDLE;
         addr_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_d  = '0;
                  state_d = STREAM;
               end
            end
            STREAM: begin
               if (slot_free) begin
                  if (addr_is_last) begin
                     addr_d  = '0;
                     state_d = FLUSH;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (out_valid && out_ready) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
      load = (state_q == STREAM) && slot_free;
   end

   aes_byte_out_reg #(
      .DATA_W(DATA_W)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (abort),
      .load_i     (load),
      .data_i     (ram_data),
      .last_i     (addr_is_last),
      .ready_i    (out_ready),
      .data_o     (out_data),
      .valid_o    (out_valid),
      .last_o     (out_last),
      .slot_free_o(slot_free)
   );

   assign ram_addr = addr_q;
   assign done     = done_q;

`ifdef AES_STATE_READER_BLOCK_OUT_EN
   logic [NUM_BYTES*DATA_W-1:0] block_q;

   // byte 0 is shifted in first so it ends up in the MSBs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         block_q <= '0;
      end else if (abort) begin
         block_q <= '0;
      end else if (out_valid && out_ready) begin
         block_q <= {block_q[NUM_BYTES*DATA_W-DATA_W-1:0], out_data};
      end
   end

   assign block_out   = block_q;
   assign block_valid = done_q;
`endif
endmodule
